rr_grant_sequencer: RTL

- Round-robin arbiter for 8 requesters.
- Outputs a registered 3-bit grant index plus a valid flag.
- The index feeds the 3-to-8 one-hot decoder stage downstream, which turns it into per-requester grant lines.
- Grants are held until released, the request drops, or a hold timeout expires; fairness comes from a rotating priority pointer.

---
 rtl/rr_grant_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer for 8 requesters.
// Issues one registered grant index at a time, holds it until the holder
// releases, withdraws its request or overstays MAX_HOLD cycles, then inserts
// one dead cycle before the next arbitration. A rotating pointer gives
// fairness: the requester after the last holder gets first look next time.
// `release` is a reserved word in SystemVerilog, so the holder's release
// input is named gnt_release.
module rr_grant_sequencer #(
    parameter int MAX_HOLD = 16,  // 0 disables the hold timeout
    parameter int CNT_W    = 8    // MAX_HOLD must fit in CNT_W bits
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       gnt_release,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout,
    output logic [2:0] ptr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam logic             TIMEOUT_EN = (MAX_HOLD > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       pick_idx;
    logic             pick_hit;
    logic             exit_rel;
    logic             exit_wd;
    logic             exit_to;
    logic             grant_exit;
    logic             timeout_hit;

    // Rotating-priority search: lowest offset from ptr with a request wins
    always_comb begin
        pick_idx = ptr;
        pick_hit = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) begin
                pick_idx = ptr + 3'(i);
                pick_hit = 1'b1;
            end
        end
    end

    // Grant exit conditions in priority order: release, withdrawal, timeout
    always_comb begin
        exit_rel    = gnt_release;
        exit_wd     = !req[gnt_idx];
        exit_to     = TIMEOUT_EN && (hold_cnt == HOLD_LAST);
        grant_exit  = exit_rel || exit_wd || exit_to;
        // A timeout only counts when nothing of higher priority ended the grant
        timeout_hit = exit_to && !exit_rel && !exit_wd;
    end

    // Sequencer state, grant registers, hold counter and rotating pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end else begin
                        gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    if (grant_exit) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 3'd1;
                        timeout   <= timeout_hit;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    // Dead cycle keeps the downstream decoder all-inactive between grants
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
